// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: FSM state encoding and a
// helper for the explicit modulo-NCH pointer wrap.
package edge_event_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Next index after idx, wrapping at nch-1 back to 0 (works for any nch).
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nch);
      return (idx == nch - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/edge_event_arbiter_chan.sv
// One channel of edge collection: input history, priming, a single pending
// event slot and a sticky overflow flag.
module edge_event_arbiter_chan (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   input  logic deq_i,
   input  logic ovf_clr_i,
   output logic pend_o,
   output logic pend_rise_o,
   output logic ovf_o
);

   logic din_q, din_d;
   logic prime_q, prime_d;
   logic pend_q, pend_d;
   logic pend_rise_q, pend_rise_d;
   logic ovf_q, ovf_d;
   logic edge_c;
   logic ovf_set_c;

   // Edge detect and slot update; a dequeue on this edge frees the slot so a
   // simultaneous new edge is stored instead of overflowing.
   always_comb begin
      din_d       = din_i;
      prime_d     = 1'b0;
      pend_d      = pend_q;
      pend_rise_d = pend_rise_q;
      ovf_set_c   = 1'b0;
      edge_c      = !prime_q && (din_i != din_q);
      if (edge_c) begin
         if (pend_q && !deq_i) begin
            ovf_set_c = 1'b1;
         end else begin
            pend_d      = 1'b1;
            pend_rise_d = din_i;
         end
      end else if (deq_i) begin
         pend_d = 1'b0;
      end
      // A new overflow beats a clear on the same edge.
      ovf_d = (ovf_q && !ovf_clr_i) || ovf_set_c;
   end

   // Channel state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_q       <= 1'b0;
         prime_q     <= 1'b1;
         pend_q      <= 1'b0;
         pend_rise_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         din_q       <= din_d;
         prime_q     <= prime_d;
         pend_q      <= pend_d;
         pend_rise_q <= pend_rise_d;
         ovf_q       <= ovf_d;
      end
   end

   assign pend_o      = pend_q;
   assign pend_rise_o = pend_rise_q;
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Dual-edge event collector: per-channel pending slots serialised by a
// round-robin arbiter onto one valid/ready event port.
// Handshake: evt_valid/evt_ch/evt_rise stay stable while evt_valid=1 and
// evt_ready=0; an event transfers on a clk edge where both are 1.
module edge_event_arbiter
   import edge_event_arbiter_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IDW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] din,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_ch,
   output logic           evt_rise,
   output logic [NCH-1:0] ovf,
   input  logic [NCH-1:0] ovf_clr
);

   if (IDW != $clog2(NCH)) begin : g_idw_check
      $error("edge_event_arbiter: IDW must equal clog2(NCH)");
   end

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] evt_ch_q, evt_ch_d;
   logic           evt_rise_q, evt_rise_d;

   logic [NCH-1:0] pend;
   logic [NCH-1:0] pend_rise;
   logic [NCH-1:0] deq;
   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   logic [IDW:0]   cand;
   logic           load;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      edge_event_arbiter_chan u_chan (
         .clk        (clk),
         .rst        (rst),
         .din_i      (din[i]),
         .deq_i      (deq[i]),
         .ovf_clr_i  (ovf_clr[i]),
         .pend_o     (pend[i]),
         .pend_rise_o(pend_rise[i]),
         .ovf_o      (ovf[i])
      );
   end

   // Round-robin pick: first pending channel at or after ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NCH)) begin
            cand = cand - (IDW+1)'(NCH);
         end
         if (!pick_found && pend[cand[IDW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDW-1:0];
         end
      end
   end

   // FSM next state: load a pick when idle or when the held event is taken.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      evt_ch_d   = evt_ch_q;
      evt_rise_d = evt_rise_q;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) load = 1'b1;
         end
         ST_HOLD: begin
            if (evt_ready) begin
               if (pick_found) load = 1'b1;
               else            state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         state_d    = ST_HOLD;
         evt_ch_d   = pick_idx;
         evt_rise_d = pend_rise[pick_idx];
         ptr_d      = (pick_idx == IDW'(NCH - 1)) ? '0 : pick_idx + IDW'(1);
      end
   end

   // One-hot dequeue strobe towards the picked channel.
   always_comb begin
      deq = '0;
      if (load) deq[pick_idx] = 1'b1;
   end

   // FSM, pointer and presented-event registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         evt_ch_q   <= '0;
         evt_rise_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         evt_ch_q   <= evt_ch_d;
         evt_rise_q <= evt_rise_d;
      end
   end

   assign evt_valid = (state_q == ST_HOLD);
   assign evt_ch    = evt_ch_q;
   assign evt_rise  = evt_rise_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a rule-level reference model.
module tb_edge_event_arbiter;

   localparam int NCH = 4;
   localparam int IDW = 2;

   // ---------------- clock / reset / DUT ----------------
   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] din;
   logic           evt_valid;
   logic           evt_ready;
   logic [IDW-1:0] evt_ch;
   logic           evt_rise;
   logic [NCH-1:0] ovf;
   logic [NCH-1:0] ovf_clr;

   always #5 clk = ~clk;

   edge_event_arbiter #(.NCH(NCH), .IDW(IDW)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_ch   (evt_ch),
      .evt_rise (evt_rise),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   int errors = 0;
   int checks = 0;

   // Accepted events seen on the port and directed expectations, {ch, rise}.
   logic [IDW:0] got_q[$];
   logic [IDW:0] exp_q[$];

   // ---------------- reference model ----------------
   bit           m_prime;
   bit [NCH-1:0] m_prev;
   bit [NCH-1:0] m_pend;
   bit [NCH-1:0] m_prise;
   bit [NCH-1:0] m_ovf;
   bit           m_valid;
   int           m_ch;
   bit           m_rise;
   int           m_ptr;

   task automatic model_step();
      int pick;
      bit accept, load, old_rise, e, dq;
      bit [NCH-1:0] set;
      if (rst) begin
         m_prime = 1; m_prev = '0; m_pend = '0; m_prise = '0; m_ovf = '0;
         m_valid = 0; m_ch = 0; m_rise = 0; m_ptr = 0;
         return;
      end
      pick = -1;
      for (int k = 0; k < NCH; k++) begin
         if (pick < 0 && m_pend[(m_ptr + k) % NCH]) pick = (m_ptr + k) % NCH;
      end
      accept   = m_valid && evt_ready;
      load     = (pick >= 0) && (!m_valid || accept);
      old_rise = (pick >= 0) ? m_prise[pick] : 1'b0;
      set      = '0;
      for (int i = 0; i < NCH; i++) begin
         e  = !m_prime && (din[i] != m_prev[i]);
         dq = load && (pick == i);
         if (e) begin
            if (m_pend[i] && !dq) set[i] = 1;
            else begin m_pend[i] = 1; m_prise[i] = din[i]; end
         end else if (dq) begin
            m_pend[i] = 0;
         end
      end
      m_ovf = (m_ovf & ~ovf_clr) | set;
      if (load) begin
         m_valid = 1; m_ch = pick; m_rise = old_rise; m_ptr = (pick + 1) % NCH;
      end else if (accept) begin
         m_valid = 0;
      end
      m_prev  = din;
      m_prime = 0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_log(input string tag);
      int n;
      check({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   // ---------------- driver ----------------
   // One clock: log any handshake, advance model, compare just after the edge.
   task automatic tick();
      if (!rst && evt_valid && evt_ready) got_q.push_back({evt_ch, evt_rise});
      @(posedge clk);
      model_step();
      #1;
      check("m_valid", 32'(evt_valid), 32'(m_valid));
      check("m_ch",    32'(evt_ch),    32'(m_ch));
      check("m_rise",  32'(evt_rise),  32'(m_rise));
      check("m_ovf",   32'(ovf),       32'(m_ovf));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1; din = 4'b0101; evt_ready = 0; ovf_clr = '0;
      #2;
      run(2);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_ch",    32'(evt_ch),    0);
      check("rst_ovf",   32'(ovf),       0);

      // Priming: lines high out of reset produce nothing.
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("prime_valid", 32'(evt_valid), 0);
      end
      check("prime_ovf", 32'(ovf), 0);

      // Bring all lines low (ch0, ch2 falls), then a single rise on ch2.
      evt_ready = 1;
      din = 4'b0000; run(6);
      got_q.delete();
      din = 4'b0100;
      tick(); check("lat_k",    32'(evt_valid), 0);
      tick(); check("lat_k1",   32'(evt_valid), 1);
              check("lat_ch",   32'(evt_ch),    2);
              check("lat_rise", 32'(evt_rise),  1);
      tick(); check("lat_one",  32'(evt_valid), 0);
      run(3);

      // Walk the pointer back to 0: ch2 fall, ch3 rise, ch3 fall.
      din = 4'b0000; run(4);
      din = 4'b1000; run(4);
      din = 4'b0000; run(4);
      got_q.delete();

      // Burst with ptr=0: 0,1,2,3 back to back.
      din = 4'b1111; tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("burst0_valid", 32'(evt_valid), 1);
         check("burst0_ch",    32'(evt_ch),    32'(i));
      end
      run(3);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back({IDW'(i), 1'b1});
      cmp_log("burst0_log");

      // Move pointer to 2 with ch1 events, then burst of falls: 2,3,0,1.
      din = 4'b1101; run(4);
      din = 4'b1111; run(4);
      got_q.delete();
      din = 4'b0000; run(8);
      exp_q.delete();
      exp_q.push_back({2'd2, 1'b0}); exp_q.push_back({2'd3, 1'b0});
      exp_q.push_back({2'd0, 1'b0}); exp_q.push_back({2'd1, 1'b0});
      cmp_log("burst2_log");

      // Glitch on ch1 with consumer stalled: rise held, fall pending, overflow.
      evt_ready = 0;
      din = 4'b0010; tick();
      din = 4'b0000; tick();
      din = 4'b0010; tick();
      check("glitch_ovf",  32'(ovf),       32'h2);
      check("glitch_ch",   32'(evt_ch),    1);
      check("glitch_rise", 32'(evt_rise),  1);
      run(2);
      check("glitch_hold", 32'(evt_valid), 1);
      got_q.delete();
      evt_ready = 1; run(4);
      exp_q.delete();
      exp_q.push_back({2'd1, 1'b1}); exp_q.push_back({2'd1, 1'b0});
      cmp_log("glitch_log");

      // Overflow and clear on the same edge: set wins; clear alone afterwards.
      evt_ready = 0;
      din = 4'b0000; run(2);
      din = 4'b0010; tick();
      din = 4'b0000; ovf_clr = 4'b0010; tick();
      check("ovf_set_wins", 32'(ovf[1]), 1);
      tick();
      check("ovf_cleared", 32'(ovf[1]), 0);
      ovf_clr = '0;
      evt_ready = 1; run(5);

      // Reset while an event is presented and three more are pending.
      evt_ready = 0;
      din = 4'b1111; run(2);
      check("mid_valid", 32'(evt_valid), 1);
      rst = 1; tick();
      check("mid_rst_valid", 32'(evt_valid), 0);
      check("mid_rst_ovf",   32'(ovf),       0);
      got_q.delete();
      rst = 0; evt_ready = 1; run(6);
      check("mid_no_stale", got_q.size(), 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NCH; i++) if ($urandom_range(0, 3) == 0) din[i] = ~din[i];
         evt_ready = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < NCH; i++) ovf_clr[i] = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 0; ovf_clr = '0; evt_ready = 1; run(8);
      check("drain_valid", 32'(evt_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel dual-edge event collector and scheduler.
- Each of NCH synchronous inputs is watched for rising and falling edges; each detected edge becomes a per-channel pending event.
- A round-robin arbiter serialises pending events onto a single valid/ready event port (channel id plus edge type) for a downstream consumer such as an interrupt or log block.
- Sits between edge-sensitive status lines and the consumer.

Parameters:
- NCH, 4, number of input channels (2..16).
- IDW, 2, width of channel id; must equal clog2(NCH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  NCH  channel inputs, already synchronous to clk.
- evt_valid  out  1  event available on evt_ch/evt_rise.
- evt_ready  in  1  consumer accepts event when evt_valid and evt_ready are both 1 at a clk edge.
- evt_ch  out  IDW  channel index of the presented event.
- evt_rise  out  1  1 = rising edge (0->1), 0 = falling edge (1->0).
- ovf  out  NCH  sticky per-channel overflow: edge lost because the channel was still pending.
- ovf_clr  in  NCH  per-bit clear of ovf.

Behaviour:
- Reset (rst=1 at clk edge) clears everything:
  - evt_valid=0, evt_ch=0, evt_rise=0, ovf=0.
  - All pending flags cleared, din_q=0, rr pointer=0, FSM=IDLE, prime=1.
  - Reset mid-transfer drops the presented event and all pending events without acknowledgement.
- Priming:
  - First clk edge after rst deasserts loads din_q<=din with no edge detection, and clears prime.
  - A line already high out of reset produces no event.
- Edge detect:
  - Once primed, each edge computes edge[i]=din[i]^din_q[i] and type rise[i]=din[i], then updates din_q<=din.
  - An edge present at clk edge k sets pend[i] and pend_rise[i] at edge k.
- Pending per channel is a single slot:
  - Edge while pend[i]=1 and i not being dequeued that same edge: keep the old event, discard the new one, set ovf[i].
  - Edge on the channel being dequeued at the same edge: the new event is stored and pend stays 1. No overflow.
  - ovf set and ovf_clr on the same bit at the same edge: set wins.
- Arbiter pick:
  - Selects the first i with pend[i]=1, searching ptr, ptr+1, ... wrapping modulo NCH.
  - On load, ptr <= picked+1 mod NCH.
- FSM (2 states):
  - IDLE: evt_valid=0. If any pend, load evt_ch/evt_rise from pick, clear that pend, go to HOLD (evt_valid=1 from the next cycle). Else stay.
  - HOLD: evt_valid=1, outputs stable until accepted.
    - On evt_valid&evt_ready with another pend: load the next pick at the same edge and stay in HOLD (back-to-back, one event per cycle).
    - On evt_valid&evt_ready with no pend: go to IDLE (evt_valid=0).
    - No ready: hold everything.
- Latency: din change sampled at edge k -> pend at k -> evt_valid high after edge k+1 when FSM is IDLE. Minimum 2 cycles from sampled change to valid.
- An edge pending on the currently picked channel at the load edge counts as a dequeue for that edge's simultaneity rule.
- A glitch of one cycle (0->1->0) yields rise, then fall on the next edge. The fall overflows if the rise is still pending.
- Widths: ptr is IDW bits, wrap is explicit (== NCH-1 -> 0) so non-power-of-2 NCH is correct.

Decomposition:
- Shared include/package edge_evt_defs: state localparams ST_IDLE=1'b0, ST_HOLD=1'b1; macro for the clog2 width check.
- Sub-module edge_chan_pend (one per channel, generate loop):
  - Contains din_q, prime gating, pend/pend_rise slot and sticky ovf.
  - Inputs: deq strobe, ovf_clr.
- Top holds the round-robin pick, ptr, FSM and output registers.

Test Plan:
- Reset with din=4'b0101 held, release, idle 5 cycles -> evt_valid stays 0, ovf=0 (priming suppresses events).
- din[2] 0->1 with evt_ready=1 -> evt_valid high 2 cycles after sample, evt_ch=2, evt_rise=1, single cycle valid, then IDLE.
- din 4'b0000->4'b1111 in one cycle, ptr=0, evt_ready=1 -> events ch 0,1,2,3 on 4 consecutive cycles, all evt_rise=1. Then ptr=0; repeat with ptr=2 start -> order 2,3,0,1.
- evt_ready=0; din[1] toggles 0->1->0 on consecutive cycles -> presented event ch1 rise held stable; fall stored pending; third toggle sets ovf[1]=1. After ready -> rise, then fall only.
- ovf_clr[1]=1 on the same edge as a new overflow on ch1 -> ovf[1] remains 1. Next cycle ovf_clr alone -> 0.
- rst asserted while evt_valid=1 with 3 pending -> next cycle evt_valid=0, ovf=0, and no stale events after release.
